// File: rtl/serial_rx_40k_pkg.sv
// Shared definitions for the 40 kbit/s serial link (receiver and sender divider).
`timescale 1ns/1ps
package serial_rx_40k_pkg;

  // 20 MHz / 500 = 40 kbit/s. The sender's bit-clock divider uses the same value.
  localparam int unsigned DEF_DIVISOR   = 500;
  localparam int unsigned DEF_DATA_BITS = 8;

  // Receiver FSM encodings
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/serial_rx_40k_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus one history flop
// for falling-edge detection. All flops reset to 1 (idle line) so releasing
// reset on a high line produces no false falling edge.
`timescale 1ns/1ps
module rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain and edge-detect history
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/serial_rx_40k.sv
// 8N1 receiver for the 40 kbit/s link. A local divide-by-DIVISOR counter times
// mid-bit samples after the start edge; no resync is done inside a frame.
`timescale 1ns/1ps
module serial_rx_40k
  import serial_rx_40k_pkg::*;
#(
  parameter int unsigned DIVISOR   = DEF_DIVISOR,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(DIVISOR);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic line_sync;
  logic line_fall;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;

  rx_sync u_rx_sync (
    .clk_i  (clock_in),
    .rst_i  (reset),
    .rx_i   (rx_in),
    .sync_o (line_sync),
    .fall_o (line_fall)
  );

  // Next-state logic: bit timing, sampling, shifting and strobe generation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (line_fall) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          // A high mid-start sample means the edge was a glitch
          if (!line_sync) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          // LSB arrives first, so shift in from the MSB side
          shift_d = {line_sync, shift_q[DATA_BITS-1:1]};
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (line_sync) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign busy        = busy_q;

endmodule

// File: doc/serial_rx_40k.md
# serial_rx_40k

Receiving end of the 40 kbit/s serial link driven by the Sender board. The block recovers 8N1 frames from the single-wire line using the local 20 MHz clock. Timing comes from an internal divide-by-DIVISOR bit counter: the receiver does not share a clock with the sender's 40 kHz bit clock. Decoded bytes are handed to the Receiver top level with a one-cycle valid strobe and a separate framing-error strobe.

## Interface
- DIVISOR, 500: clock_in cycles per bit (20 MHz / 500 = 40 kbit/s); must be even and ≥ 4
- DATA_BITS, 8: data bits per frame, LSB first
- clock_in  input  1  20 MHz system clock
- reset  input  1  asynchronous, active-high reset
- rx_in  input  1  serial line, idle high, asynchronous to clock_in
- data_out  output  DATA_BITS  last correctly framed byte
- data_valid  output  1  one-cycle pulse when data_out updates
- frame_error  output  1  one-cycle pulse when the stop bit samples low
- busy  output  1  high while a frame is in progress (any state other than IDLE)

## Operation
- rx_in passes through a 2-flop synchronizer, then a third flop for edge detection.
  - fall = prev & ~sync.
  - The FSM acts only on synchronized values.
- FSM states: IDLE, START, DATA, STOP.
- Bit counter (cnt) is a ceil(log2(DIVISOR))-bit register; bit index is a 0..DATA_BITS-1 register.
- IDLE
  - cnt = 0.
  - On fall, go to START.
  - A line that is held low never produces a second fall, so no re-arm until it returns high.
- START
  - cnt counts up; at cnt == DIVISOR/2−1, sample sync.
  - If sample is 0: cnt ← 0 and go to DATA.
  - If sample is 1 (glitch): go to IDLE silently.
- DATA
  - At cnt == DIVISOR−1, sample, shift into shift register MSB-side (so the LSB lands first), cnt ← 0, increment index.
  - After bit DATA_BITS−1, go to STOP.
- STOP
  - At cnt == DIVISOR−1, sample.
  - If 1: data_out ← shift register, pulse data_valid.
  - If 0: pulse frame_error; data_out keeps its previous value.
  - Either way, go to IDLE.
- data_valid and frame_error are mutually exclusive and never high for more than one cycle.
- rx_in activity outside IDLE other than at sample points is ignored; there is no mid-frame resync.
- Reset asserted mid-frame aborts the frame immediately with no strobe.
- Reset values:
  - FSM = IDLE, cnt = 0, index = 0, shift register = 0
  - data_out = 0, data_valid = 0, frame_error = 0, busy = 0
  - synchronizer flops = 1 (idle line, so reset release on a high line creates no false fall)

## Timing
- Let E be the cycle in which fall is seen (pin falling edge + 2 clock_in edges).
- Start sample at E+DIVISOR/2 (E+250).
- Data bit k (k = 0..7) sampled at E+DIVISOR/2+(k+1)·DIVISOR.
- Stop sample at E+DIVISOR/2+(DATA_BITS+1)·DIVISOR (E+4750).
- data_valid / frame_error high during the cycle after the stop sample (E+4751); busy falls in that same cycle.
- Back-to-back frames: a start edge arriving any time after the stop sample is accepted, because IDLE is entered at E+4751 and fall is evaluated there.
- Tolerates ±2 % sender/receiver clock mismatch, since mid-bit sampling leaves ±250 cycles of margin across 9.5 bit times.

## Structure
- Shared package/header holds:
  - DIVISOR and DATA_BITS defaults (also used by the Sender's clock divider, so both ends stay consistent)
  - FSM state encodings: IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3
- One sub-module, rx_sync: the 3-flop synchronizer with reset-to-1, outputting sync and fall.
- Counter, FSM, shift register and output registers live in serial_rx_40k.

## Test plan
- Reset held 10 cycles, rx_in high, then released → all outputs 0, busy 0; no strobe for 10 000 cycles.
- Frame 0xA5 at exactly 500 cycles/bit → busy rises 1 cycle after E; single data_valid pulse at E+4751 with data_out = 8'hA5; frame_error stays 0.
- Back-to-back 0x00 then 0xFF, no idle gap, sender bit time 490 cycles (−2 %) → two data_valid pulses, data_out 8'h00 then 8'hFF.
- 100-cycle low glitch on idle line → START aborts at E+250; busy drops; no data_valid or frame_error.
- Frame 0x3C with stop bit 0, line then held low 20 000 cycles → one frame_error pulse at E+4751; data_out unchanged; no further activity until the line returns high and a new start bit is sent.
- Reset asserted at E+2000 mid-frame, released 5 cycles later, then frame 0x5A → no strobe from the aborted frame; data_valid with data_out = 8'h5A for the new frame.
